// File: rtl/fsm_pkg.sv
// Shared definitions for the serial-detector FSM blocks and their pattern source.
// Holds the transmitter state type and its default frame constants.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  localparam logic [4:0] TX_PATTERN_DEF = 5'b11011;
  localparam int         TX_GAP_DEF     = 2;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle of seq_pattern_tx; master drives requests, slave is the transmitter.
// Bundle only, no latency; transmitter has no backpressure input.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 5,
  parameter int REPW  = 4
);
  logic             start;
  logic [REPW-1:0]  reps;
  logic             pat_load;
  logic [WIDTH-1:0] pat_in;
  logic             out;
  logic             valid;
  logic             frame;
  logic             busy;
  logic             done;

  modport master (
    output start, reps, pat_load, pat_in,
    input  out, valid, frame, busy, done
  );

  modport slave (
    input  start, reps, pat_load, pat_in,
    output out, valid, frame, busy, done
  );
endinterface

// File: rtl/pattern_shift_reg.sv
// Parallel-load, left-shifting register; the MSB flop is the serial tap and zeros fill from the LSB.
// One-cycle load/shift latency; load wins over shift, no backpressure.
module pattern_shift_reg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  output logic             msb
);
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Sends `reps` WIDTH-bit frames MSB-first with GAP idle zeros between; first bit one cycle after start.
// All outputs registered; no backpressure, start/pat_load are ignored unless idle.
module seq_pattern_tx #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(fsm_pkg::TX_PATTERN_DEF),
  parameter int               GAP     = fsm_pkg::TX_GAP_DEF,
  parameter int               REPW    = 4
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);
  import fsm_pkg::*;

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  localparam tx_state_t ST_IDLE = IDLE;
  localparam tx_state_t ST_SEND = SEND;
  localparam tx_state_t ST_GAP  = fsm_pkg::GAP;
  localparam tx_state_t ST_DONE = DONE;

  tx_state_t        state, state_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [REPW-1:0]  frm_cnt, frm_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic [WIDTH-1:0] pat_reg, load_val;
  logic             sr_load, sr_shift;

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    frm_nxt   = frm_cnt;
    gap_nxt   = gap_cnt;
    load_val  = pat_reg;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && bus.reps != '0) begin
          state_nxt = ST_SEND;
          frm_nxt   = bus.reps;
          bit_nxt   = '0;
          sr_load   = 1'b1;
          // A same-cycle pattern load is the frame that goes out.
          if (bus.pat_load) load_val = bus.pat_in;
        end
      end
      ST_SEND: begin
        if (bit_cnt == BIT_LAST) begin
          bit_nxt = '0;
          frm_nxt = (frm_cnt != '0) ? frm_cnt - 1'b1 : frm_cnt;
          if (frm_cnt <= REPW'(1)) begin
            state_nxt = ST_DONE;
            sr_shift  = 1'b1;
          end else if (GAP == 0) begin
            sr_load = 1'b1;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = '0;
            sr_shift  = 1'b1;
          end
        end else begin
          bit_nxt  = bit_cnt + 1'b1;
          sr_shift = 1'b1;
        end
      end
      ST_GAP: begin
        // The register has already shifted out to zeros; reload as the gap closes.
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_SEND;
          sr_load   = 1'b1;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      frm_cnt   <= '0;
      gap_cnt   <= '0;
      pat_reg   <= PATTERN;
      bus.valid <= 1'b0;
      bus.frame <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      frm_cnt <= frm_nxt;
      gap_cnt <= gap_nxt;
      if (state == ST_IDLE && bus.pat_load) pat_reg <= bus.pat_in;
      bus.valid <= (state_nxt == ST_SEND);
      bus.frame <= sr_load;
      bus.busy  <= (state_nxt == ST_SEND) || (state_nxt == ST_GAP);
      bus.done  <= (state_nxt == ST_DONE);
    end
  end

  // `out` is the shift register's MSB flop, so it is zero whenever no frame is in flight.
  pattern_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_val (load_val),
    .msb      (bus.out)
  );
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: the producing end of the serial-detector interface used by the FSM blocks. It shifts a programmable WIDTH-bit pattern out MSB-first, one bit per clock, for a requested number of frames. It inserts GAP idle-zero cycles between frames. Its `out` line drives a sequence detector's `in` directly; with default parameters it emits `11011` frames for the non-overlapping Moore detector `moore_11011_nonoverlapping`.

## Interface
- `WIDTH`, 5, pattern length in bits (2..16)
- `PATTERN`, 5'b11011, pattern register value after reset
- `GAP`, 2, idle cycles between consecutive frames (0..15)
- `REPW`, 4, width of `reps`
- `clk`  in  1  rising-edge clock, the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request transmission; sampled only in IDLE
- `reps`  in  REPW  number of frames to send; sampled with `start`
- `pat_load`  in  1  load `pat_in` into pattern register; honoured only in IDLE
- `pat_in`  in  WIDTH  new pattern
- `out`  out  1  serial data bit, registered
- `valid`  out  1  high while `out` carries a pattern bit
- `frame`  out  1  high on the first (MSB) bit of each frame
- `busy`  out  1  high in SEND and GAP
- `done`  out  1  one-cycle pulse after the last bit of the last frame

## Operation
- States:
  - IDLE: waiting for `start`.
  - SEND: shifting a frame out.
  - GAP: idle zeros between frames.
  - DONE: one cycle, signals completion.
- IDLE → SEND on `start`=1 with `reps`≠0. `reps` latches into the frame counter and the pattern copies into the shift register.
- `start` with `reps`=0 is ignored: the block stays in IDLE and `done` is not pulsed.
- SEND: `out` = shift[WIDTH-1], `valid`=1. The shift register shifts left each cycle and the bit counter increments.
- After bit WIDTH-1 of a frame:
  - If more frames remain: go to GAP, or straight to SEND when GAP=0.
  - Otherwise: go to DONE.
- GAP: `out`=0, `valid`=0 for exactly GAP cycles. The shift register reloads from the pattern register on the final GAP cycle.
- DONE: `done`=1, `busy`=0, `out`=0. The next state is always IDLE.
- `start` in SEND/GAP/DONE is ignored; there is no queuing.
- `pat_load` outside IDLE is ignored. A transmission in progress always uses the pattern captured at start.
- `pat_load` and `start` in the same IDLE cycle: `pat_in` is written to the pattern register and is also the frame sent.
- Counters:
  - Bit counter: width ceil(log2(WIDTH)), clears at each frame start.
  - Frame counter: REPW bits, decrements at each frame end, no wrap. Transmission ends when the counter reaches 1 at a frame end.

## Timing
- Reset values:
  - `out`=0, `valid`=0, `frame`=0, `busy`=0, `done`=0.
  - State = IDLE, counters = 0.
  - Pattern register = PATTERN.
- Reset mid-transmission: outputs drop immediately (asynchronously) to their reset values. The pattern register also reverts to PATTERN.
- Latency: `start` sampled at edge k → first bit on `out`, with `valid`=`frame`=`busy`=1, during cycle k+1.
- Busy duration is reps·WIDTH + (reps−1)·GAP cycles, followed by one `done` cycle.
- Earliest accepted re-start is the cycle after `done`, i.e. in IDLE. Back-to-back starts are separated by at least one IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared package `fsm_pkg` holds:
  - the state enum `tx_state_t` {IDLE, SEND, GAP, DONE};
  - default constants `TX_PATTERN_DEF`=5'b11011 and `TX_GAP_DEF`=2.
- The natural sub-module is `pattern_shift_reg`, a parallel-load, left-shifting register with MSB tap. The FSM and both counters stay in `seq_pattern_tx`.

## Test plan
- Reset, then `start`=1, `reps`=1 → `out` = 1,1,0,1,1 on cycles k+1..k+5 with `valid`=1; `frame`=1 on k+1 only; `done`=1 on k+6; `busy` low from k+6.
- `reps`=3, GAP=2 → 1101100110110011011 on `out`. `valid` is low on the four gap cycles. `frame` pulses at offsets 0, 7, 14. `done` at offset 19.
- `pat_load`=1, `pat_in`=5'b10110 in IDLE, then `start`, `reps`=1 → `out` = 1,0,1,1,0.
- `pat_load` of 5'b00000 during SEND → the current and later frames of that transmission still send 11011.
- `start` pulsed during SEND → ignored, with no extra frame. `start` with `reps`=0 → `busy` stays 0 and `done` never pulses.
- `rst` asserted mid-frame (after 3 bits) → all outputs 0 at once and the state returns to IDLE. A following `start` sends a full 11011.
- Loop-back: `out` → `moore_11011_nonoverlapping.in` with `reps`=2 and GAP=0 → the detector asserts its output exactly twice, once after each frame's final bit.
